// File: rtl/snitch_icache_refill_arbiter.sv
// snitch_icache_refill_arbiter: round-robin merge of per-handler icache refills onto one port.
// Revision 1.0
`default_nettype none

module snitch_icache_refill_arbiter #(
  parameter int unsigned NR_PORTS        = 2,
  parameter int unsigned FETCH_AW        = 32,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned IN_ID_WIDTH     = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned PORT_IW        = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
  localparam int unsigned OUT_ID_WIDTH   = PORT_IW + IN_ID_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic [FETCH_AW-1:0]     in_req_addr_i  [NR_PORTS],
  input  logic [IN_ID_WIDTH-1:0]  in_req_id_i    [NR_PORTS],
  input  logic [NR_PORTS-1:0]     in_req_valid_i,
  output logic [NR_PORTS-1:0]     in_req_ready_o,

  output logic [LINE_WIDTH-1:0]   in_rsp_data_o  [NR_PORTS],
  output logic [NR_PORTS-1:0]     in_rsp_error_o,
  output logic [IN_ID_WIDTH-1:0]  in_rsp_id_o    [NR_PORTS],
  output logic [NR_PORTS-1:0]     in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]     in_rsp_ready_i,

  output logic [FETCH_AW-1:0]     out_req_addr_o,
  output logic [OUT_ID_WIDTH-1:0] out_req_id_o,
  output logic                    out_req_valid_o,
  input  logic                    out_req_ready_i,

  input  logic [LINE_WIDTH-1:0]   out_rsp_data_i,
  input  logic                    out_rsp_error_i,
  input  logic [OUT_ID_WIDTH-1:0] out_rsp_id_i,
  input  logic                    out_rsp_valid_i,
  output logic                    out_rsp_ready_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PORT_IW-1:0]  rr_q;
  logic [PORT_IW-1:0]  lock_idx_q;
  logic                lock_q;
  logic [PORT_IW-1:0]  arb_idx;
  logic                arb_found;
  logic [PORT_IW-1:0]  grant;
  logic                req_hs;
  logic [NR_PORTS-1:0] eligible;
  logic [NR_PORTS-1:0] rsp_hs;
  logic [PORT_IW-1:0]  rsp_port;
  logic [CNT_W-1:0]    cnt_q [NR_PORTS];

  function automatic logic [PORT_IW-1:0] port_add(input logic [PORT_IW-1:0] base,
                                                  input int unsigned off);
    int unsigned sum;
    sum = int'(base) + off;
    if (sum >= NR_PORTS) sum = sum - NR_PORTS;
    return sum[PORT_IW-1:0];
  endfunction

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_elig
    assign eligible[p] = in_req_valid_i[p] && (cnt_q[p] < CNT_W'(MAX_OUTSTANDING));
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (!arb_found && eligible[port_add(rr_q, i)]) begin
        arb_found = 1'b1;
        arb_idx   = port_add(rr_q, i);
      end
    end
  end

  // A stalled grant stays pinned so address and ID cannot change while valid.
  assign grant           = lock_q ? lock_idx_q : arb_idx;
  assign out_req_valid_o = lock_q ? eligible[lock_idx_q] : arb_found;
  assign out_req_addr_o  = in_req_addr_i[grant];
  assign out_req_id_o    = {grant, in_req_id_i[grant]};
  assign req_hs          = out_req_valid_o && out_req_ready_i;

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_req_rdy
    assign in_req_ready_o[p] = req_hs && (grant == PORT_IW'(p));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (req_hs) begin
      rr_q       <= port_add(grant, 1);
      lock_q     <= 1'b0;
    end else begin
      lock_q     <= out_req_valid_o;
      lock_idx_q <= grant;
    end
  end

  assign rsp_port = out_rsp_id_i[OUT_ID_WIDTH-1 -: PORT_IW];

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_rsp
    assign in_rsp_data_o[p]  = out_rsp_data_i;
    assign in_rsp_error_o[p] = out_rsp_error_i;
    assign in_rsp_id_o[p]    = out_rsp_id_i[IN_ID_WIDTH-1:0];
    assign in_rsp_valid_o[p] = out_rsp_valid_i && (rsp_port == PORT_IW'(p));
    assign rsp_hs[p]         = in_rsp_valid_o[p] && in_rsp_ready_i[p];
  end

  // Responses addressed to a nonexistent port are sunk.
  always_comb begin
    out_rsp_ready_o = 1'b1;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      if (rsp_port == PORT_IW'(p)) out_rsp_ready_o = in_rsp_ready_i[p];
    end
  end

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_cnt
    logic inc;
    logic dec;
    assign inc = req_hs && (grant == PORT_IW'(p));
    assign dec = rsp_hs[p];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q[p] <= '0;
      end else if (inc && !dec) begin
        cnt_q[p] <= cnt_q[p] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[p] != '0)) begin
        cnt_q[p] <= cnt_q[p] - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
